data_memory_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the data memory. Shares the single `dataMemory` read/write port between the core's load/store unit (port 0) and an auxiliary master such as a loader or debug port (port 1). Port 0 has priority by default; a starvation counter guarantees port 1 service. The block sits between both masters and `dataMemory`, and it alone drives the memory's read, write, address and write-data inputs.

---
 rtl/data_memory_arbiter_pkg.sv | 19 +
 rtl/data_memory_arbiter_if.sv | 30 +++
 rtl/data_memory_arbiter.sv | 79 +++++++
 tb/tb_data_memory_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
// DATA_WIDTH sets the data width and the address width, because the memory
// spans the full address space. arbState_t is the sequencer state encoding.
// memReq_t is one latched access.
package data_memory_arbiter_pkg;

  localparam int DATA_WIDTH           = 8;
  localparam int STARVE_LIMIT_DEFAULT = 4;
  localparam int STARVE_W             = 4;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_DONE} arbState_t;

  typedef struct packed {
    logic                  write;
    logic [DATA_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] value;
  } memReq_t;

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Bundle that connects the two requesters, the arbiter and dataMemory.
//   _req*/_write*/_address*/_valueIn* : requester -> arbiter
//   ack0/ack1/valueOut                : arbiter -> requesters
//   memRead/memWrite/memAddress/memValueIn : arbiter -> memory
//   _memValueOut                      : memory (combinational read) -> arbiter
// The slave modport is the arbiter side. The master modport is the
// requester/memory side.
interface data_memory_arbiter_if;
  import data_memory_arbiter_pkg::*;

  logic                  _req0, _write0, _req1, _write1;
  logic [DATA_WIDTH-1:0] _address0, _valueIn0, _address1, _valueIn1;
  logic                  ack0, ack1;
  logic [DATA_WIDTH-1:0] valueOut;
  logic                  memRead, memWrite;
  logic [DATA_WIDTH-1:0] memAddress, memValueIn, _memValueOut;

  modport slave (
    input  _req0, _write0, _address0, _valueIn0,
           _req1, _write1, _address1, _valueIn1, _memValueOut,
    output ack0, ack1, valueOut, memRead, memWrite, memAddress, memValueIn
  );

  modport master (
    output _req0, _write0, _address0, _valueIn0,
           _req1, _write1, _address1, _valueIn1, _memValueOut,
    input  ack0, ack1, valueOut, memRead, memWrite, memAddress, memValueIn
  );

endinterface

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter and access sequencer in front of the single-port dataMemory.
// Port 0 has priority. Port 1 is forced to win after STARVE_LIMIT contended
// losses. STARVE_LIMIT must be in the range 1..15.
// Each access takes three cycles: IDLE (arbitrate and latch), ACCESS (memory
// strobe) and DONE (ack pulse).
// Ports:
//   _CLK : clock, rising edge
//   _RST : asynchronous, active-high reset
//   bus  : data_memory_arbiter_if.slave (requesters + memory side)
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                  _CLK,
  input  logic                  _RST,
  data_memory_arbiter_if.slave  bus
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  arbState_t             state_q;
  memReq_t               hold_q, pick;
  logic                  winner_q;
  logic                  grant1, anyReq, inAccess;
  logic [STARVE_W-1:0]   starveCnt_q, starveCnt_d;
  logic [DATA_WIDTH-1:0] valueOut_q;

  // Arbitration. The result is only consumed in IDLE.
  always_comb begin
    anyReq = bus._req0 | bus._req1;
    grant1 = bus._req1 & (~bus._req0 | (starveCnt_q == LIMIT));
    pick   = grant1 ? '{write: bus._write1, address: bus._address1, value: bus._valueIn1}
                    : '{write: bus._write0, address: bus._address0, value: bus._valueIn0};
    starveCnt_d = starveCnt_q;
    if (grant1)
      starveCnt_d = '0;
    else if (bus._req0 & bus._req1 & (starveCnt_q != LIMIT))
      starveCnt_d = starveCnt_q + 1'b1;
  end

  always_ff @(posedge _CLK or posedge _RST) begin
    if (_RST) begin
      state_q     <= ARB_IDLE;
      hold_q      <= '0;
      winner_q    <= 1'b0;
      starveCnt_q <= '0;
      valueOut_q  <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: if (anyReq) begin
          hold_q      <= pick;
          winner_q    <= grant1;
          starveCnt_q <= starveCnt_d;
          state_q     <= ARB_ACCESS;
        end
        ARB_ACCESS: begin
          // A write reports 0 on valueOut. A read captures the memory's
          // combinational output.
          valueOut_q <= hold_q.write ? '0 : bus._memValueOut;
          state_q    <= ARB_DONE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // The outputs are decoded only from registers. An asynchronous reset
  // therefore removes the memory strobe and the ack in the same instant.
  assign inAccess       = (state_q == ARB_ACCESS);
  assign bus.memRead    = inAccess & ~hold_q.write;
  assign bus.memWrite   = inAccess &  hold_q.write;
  assign bus.memAddress = inAccess ? hold_q.address : '0;
  assign bus.memValueIn = (inAccess & hold_q.write) ? hold_q.value : '0;
  assign bus.ack0       = (state_q == ARB_DONE) & ~winner_q;
  assign bus.ack1       = (state_q == ARB_DONE) &  winner_q;
  assign bus.valueOut   = valueOut_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter. A stand-in dataMemory (combinational read,
// write on the clock edge) sits behind the arbiter. The reference model works
// per transaction: it tracks pending requests, arbitration losses and memory
// contents as plain arrays.
module tb_data_memory_arbiter;
  import data_memory_arbiter_pkg::*;

  localparam int LIMIT = 4;
  typedef logic [DATA_WIDTH-1:0] word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  data_memory_arbiter_if bus();
  data_memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (._CLK(clk), ._RST(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // dataMemory stand-in. It is cleared on the first edge, while reset is held.
  word_t mem [0:255];
  logic  memClear = 1'b1;
  always @(posedge clk) begin
    if (memClear) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      memClear <= 1'b0;
    end else if (bus.memWrite) mem[bus.memAddress] <= bus.memValueIn;
  end
  assign bus._memValueOut = mem[bus.memAddress];

  // Reference state
  int      modelMem [0:255];
  int      mStarve;
  bit      pend0, pend1;
  memReq_t q0, q1;
  int      checks = 0, failures = 0;
  int      ackCyc;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic memReq_t mkReq(logic wr, int a, int v);
    memReq_t r;
    r.write = wr; r.address = word_t'(a); r.value = word_t'(v);
    return r;
  endfunction

  function automatic memReq_t randReq();
    return mkReq(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 255));
  endfunction

  task automatic drive();
    bus._req0 = pend0; bus._write0 = q0.write; bus._address0 = q0.address; bus._valueIn0 = q0.value;
    bus._req1 = pend1; bus._write1 = q1.write; bus._address1 = q1.address; bus._valueIn1 = q1.value;
  endtask

  // Runs one access, starting in an IDLE cycle with the requests driven. It
  // returns the port whose ack was seen (-1 if none) and leaves the bench in
  // cycle N+3.
  task automatic slot(output int obs);
    int      win;
    memReq_t w;
    int      expV;
    obs = -1;
    if (!pend0 && !pend1) begin
      @(posedge clk); #1;
      chk("idle_strobes", {bus.memRead, bus.memWrite, bus.ack0, bus.ack1}, 4'b0);
      return;
    end
    // Port 1 wins when it is alone, or when it has lost LIMIT contended rounds
    // in a row.
    win = (pend1 && (!pend0 || mStarve == LIMIT)) ? 1 : 0;
    if (win == 1) mStarve = 0;
    else if (pend1) mStarve = (mStarve + 1 > LIMIT) ? LIMIT : mStarve + 1;
    w = (win == 1) ? q1 : q0;

    @(posedge clk); #1;  // ACCESS
    chk("acc_read",  bus.memRead,  !w.write);
    chk("acc_write", bus.memWrite, w.write);
    chk("acc_addr",  bus.memAddress, w.address);
    chk("acc_wdata", bus.memValueIn, w.write ? w.value : '0);
    chk("acc_noack", {bus.ack1, bus.ack0}, 2'b00);
    chk("starve",    dut.starveCnt_q, mStarve);
    expV = w.write ? 0 : modelMem[w.address];
    if (w.write) modelMem[w.address] = w.value;

    @(posedge clk); #1;  // DONE
    chk("done_ack",     {bus.ack1, bus.ack0}, (win == 1) ? 2'b10 : 2'b01);
    chk("done_value",   bus.valueOut, expV);
    chk("done_strobes", {bus.memRead, bus.memWrite}, 2'b00);
    if (bus.ack1) obs = 1; else if (bus.ack0) obs = 0;
    if (bus.ack0 || bus.ack1) ackCyc = cyc;

    @(posedge clk); #1;  // back to IDLE, cycle N+3
  endtask

  initial begin
    int obs, firstAck;
    int expOrder [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int expCnt   [10] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};

    for (int i = 0; i < 256; i++) modelMem[i] = 0;
    mStarve = 0; pend0 = 0; pend1 = 0; q0 = '0; q1 = '0;
    drive();

    // Reset state
    #1;
    chk("rst_ack",   {bus.ack1, bus.ack0}, 2'b00);
    chk("rst_strb",  {bus.memRead, bus.memWrite}, 2'b00);
    chk("rst_addr",  bus.memAddress, 0);
    chk("rst_wdata", bus.memValueIn, 0);
    chk("rst_value", bus.valueOut, 0);
    chk("rst_cnt",   dut.starveCnt_q, 0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Port 0 writes 0x5A to 0x10, then reads it back
    pend0 = 1; q0 = mkReq(1, 'h10, 'h5A); drive();
    slot(obs); chk("p0_wr_win", obs, 0);
    q0 = mkReq(0, 'h10, 0); drive();
    slot(obs); chk("p0_rd_win", obs, 0);
    chk("p0_rd_mem", mem['h10], 'h5A);

    // Preload 0x20 and 0x08 through port 0
    q0 = mkReq(1, 'h20, 'h33); drive(); slot(obs);
    q0 = mkReq(1, 'h08, 'hAB); drive(); slot(obs);
    pend0 = 0; drive();

    // Port 1 alone reads 0x20
    pend1 = 1; q1 = mkReq(0, 'h20, 0); drive();
    slot(obs); chk("p1_rd_win", obs, 1);
    chk("p1_rd_cnt", dut.starveCnt_q, 0);

    // Both ports write to 0x05 in the same cycle
    pend0 = 1; q0 = mkReq(1, 'h05, 'h11);
    pend1 = 1; q1 = mkReq(1, 'h05, 'h22); drive();
    slot(obs); chk("sim_first", obs, 0);
    chk("sim_mem_first", mem['h05], 'h11);
    pend0 = 0; drive();
    slot(obs); chk("sim_second", obs, 1);
    pend1 = 0; pend0 = 1; q0 = mkReq(0, 'h05, 0); drive();
    slot(obs);
    chk("sim_final", mem['h05], 'h22);

    // Continuous contention: both ports keep their requests high
    pend0 = 1; q0 = mkReq(0, 'h10, 0);
    pend1 = 1; q1 = mkReq(0, 'h20, 0); drive();
    for (int i = 0; i < 10; i++) begin
      slot(obs);
      chk("cont_order", obs, expOrder[i]);
      chk("cont_cnt",   dut.starveCnt_q, expCnt[i]);
    end
    pend1 = 0; drive();

    // Handshake: req0 stays high across ack0
    q0 = mkReq(1, 'h30, 'h77); drive();
    slot(obs); firstAck = ackCyc;
    slot(obs); chk("hs_second", obs, 0);
    chk("hs_spacing", ackCyc - firstAck, 3);
    pend0 = 0; drive();

    // Reset in the middle of a port 0 write of 0xFF to 0x08
    pend0 = 1; q0 = mkReq(1, 'h08, 'hFF); drive();
    @(posedge clk); #1;
    chk("rw_pre_write", bus.memWrite, 1);
    #2 rst = 1'b1;
    #1;
    chk("rw_strobes", {bus.memRead, bus.memWrite, bus.ack0, bus.ack1}, 4'b0);
    chk("rw_addr",    bus.memAddress, 0);
    chk("rw_wdata",   bus.memValueIn, 0);
    pend0 = 0; drive();
    @(negedge clk); @(negedge clk); rst = 1'b0; mStarve = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rw_no_ack", {bus.ack1, bus.ack0}, 2'b00);
    end
    chk("rw_mem_kept", mem['h08], modelMem['h08]);
    pend1 = 1; q1 = mkReq(0, 'h08, 0); drive();
    slot(obs); chk("rw_readback_win", obs, 1);
    pend1 = 0; drive();

    // Reset asserted during DONE removes the ack immediately
    pend0 = 1; q0 = mkReq(0, 'h10, 0); drive();
    @(posedge clk); #1; @(posedge clk); #1;
    chk("rd_ack_before", bus.ack0, 1);
    rst = 1'b1; #1;
    chk("rd_ack_after", {bus.ack1, bus.ack0}, 2'b00);
    pend0 = 0; drive();
    @(negedge clk); rst = 1'b0; mStarve = 0;
    @(posedge clk); #1;

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      if (!pend0 && $urandom_range(0, 9) < 5) begin pend0 = 1; q0 = randReq(); end
      if (!pend1 && $urandom_range(0, 9) < 5) begin pend1 = 1; q1 = randReq(); end
      drive();
      slot(obs);
      if (obs == 0) pend0 = 0;
      if (obs == 1) pend1 = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
